// File: rtl/mem_arbiter.sv
// Three-requester arbiter for a single-port synchronous memory.
// Rotating priority, per-requester lock with a bounded hold time, registered read-valid.
module mem_arbiter #(
   parameter int AW       = 5,
   parameter int DW       = 8,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req,
   input  logic [2:0]        lock,
   input  logic [2:0]        req_we,
   input  logic [3*AW-1:0]   req_addr,
   input  logic [3*DW-1:0]   req_wdata,
   output logic [2:0]        gnt,
   output logic [2:0]        rvalid,
   output logic [DW-1:0]     rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_din,
   input  logic [DW-1:0]     mem_dout,
   output logic [1:0]        owner
);

   typedef enum logic {ARB, LOCKED} state_t;

   localparam logic [1:0] NONE = 2'd3;

   state_t      state;
   logic [1:0]  last;
   logic [7:0]  lcnt;
   logic [1:0]  ign_id;
   logic [1:0]  arb_win;
   logic [1:0]  win;
   logic        hold;
   logic        relock;
   logic        lcnt_done;
   logic [3:0]  req_x;
   logic [3:0]  lock_x;

   // Rotating scan: last+1, last+2, last; returns NONE when nothing is requested.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
      logic [1:0] c0;
      logic [1:0] c1;
      c0 = (l == 2'd2) ? 2'd0 : l + 2'd1;
      c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
      pick = NONE;
      if (r[c0])
         pick = c0;
      else if (r[c1])
         pick = c1;
      else if (r[l])
         pick = l;
   endfunction

   always_comb begin
      req_x     = {1'b0, req};
      lock_x    = {1'b0, lock};
      arb_win   = pick(req_x, last);
      hold      = (state == LOCKED) && lock_x[owner];
      win       = hold ? (req_x[owner] ? owner : NONE) : arb_win;
      // The former owner's lock is disregarded for one cycle after a forced release.
      relock    = (win != NONE) && lock_x[win] && (win != ign_id);
      lcnt_done = ({1'b0, lcnt} + 9'd1) >= 9'(MAX_LOCK);
   end

   always_comb begin
      gnt      = '0;
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (!rst) begin
         case (win)
            2'd0: begin
               gnt      = 3'b001;
               mem_en   = 1'b1;
               mem_we   = req_we[0];
               mem_addr = req_addr[AW-1:0];
               mem_din  = req_wdata[DW-1:0];
            end
            2'd1: begin
               gnt      = 3'b010;
               mem_en   = 1'b1;
               mem_we   = req_we[1];
               mem_addr = req_addr[2*AW-1:AW];
               mem_din  = req_wdata[2*DW-1:DW];
            end
            2'd2: begin
               gnt      = 3'b100;
               mem_en   = 1'b1;
               mem_we   = req_we[2];
               mem_addr = req_addr[3*AW-1:2*AW];
               mem_din  = req_wdata[3*DW-1:2*DW];
            end
            default: ;
         endcase
      end
   end

   assign rdata = (|rvalid) ? mem_dout : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ARB;
         last   <= 2'd2;
         owner  <= NONE;
         lcnt   <= '0;
         ign_id <= NONE;
         rvalid <= '0;
      end else begin
         rvalid <= gnt & ~req_we;
         if (win != NONE)
            last <= win;
         ign_id <= NONE;
         if (hold) begin
            if (lcnt_done) begin
               state  <= ARB;
               owner  <= NONE;
               lcnt   <= '0;
               ign_id <= owner;
            end else begin
               lcnt <= lcnt + 8'd1;
            end
         end else if (relock) begin
            state <= LOCKED;
            owner <= win;
            lcnt  <= 8'd1;
         end else begin
            state <= ARB;
            owner <= NONE;
            lcnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table-driven per-cycle vectors plus
// hand-written reset and forced-release sequences, against a simple memory model.
module tb_mem_arbiter;

   localparam int AW = 5;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      req, lock, req_we;
   logic [3*AW-1:0] req_addr;
   logic [3*DW-1:0] req_wdata;
   logic [2:0]      gnt, rvalid;
   logic [DW-1:0]   rdata;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_din, mem_dout;
   logic [1:0]      owner;

   logic [DW-1:0]   mem [32];

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0]  req, lock, we;
      logic [14:0] addr;
      logic [23:0] wdata;
      logic [2:0]  gnt, rvalid;
      logic [7:0]  rdata;
      logic [1:0]  owner;
      logic        en, mwe;
      logic [4:0]  maddr;
      logic [7:0]  mdin;
   } vec_t;

   vec_t tbl[$];

   localparam logic [14:0] A  = {5'd3, 5'd2, 5'd1};
   localparam logic [14:0] A5 = {5'd3, 5'd5, 5'd1};
   localparam logic [23:0] W  = {8'hC2, 8'hB1, 8'hA0};
   localparam logic [23:0] W5 = {8'hC2, 8'hA5, 8'hA0};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_din;
         else        mem_dout      <= mem[mem_addr];
      end
   end

   mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(8)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .owner(owner)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] we,
                      input logic [14:0] ad, input logic [23:0] wd,
                      input logic [2:0] eg, input logic [2:0] erv, input logic [7:0] erd,
                      input logic [1:0] eo, input logic een, input logic emwe,
                      input logic [4:0] ema, input logic [7:0] emd);
      vec_t v;
      v.req = rq; v.lock = lk; v.we = we; v.addr = ad; v.wdata = wd;
      v.gnt = eg; v.rvalid = erv; v.rdata = erd; v.owner = eo;
      v.en = een; v.mwe = emwe; v.maddr = ema; v.mdin = emd;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] we,
                        input logic [14:0] ad, input logic [23:0] wd);
      req = rq; lock = lk; req_we = we; req_addr = ad; req_wdata = wd;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h40 + 8'(i);
      mem_dout = '0;

      // Round robin over three readers; memory holds 40h+addr.
      add(3'b111, 3'b000, 3'b000, A, W, 3'b001, 3'b000, 8'h00, 2'd3, 1, 0, 5'd1, 8'h00);
      add(3'b111, 3'b000, 3'b000, A, W, 3'b010, 3'b001, 8'h41, 2'd3, 1, 0, 5'd2, 8'h00);
      add(3'b111, 3'b000, 3'b000, A, W, 3'b100, 3'b010, 8'h42, 2'd3, 1, 0, 5'd3, 8'h00);
      add(3'b111, 3'b000, 3'b000, A, W, 3'b001, 3'b100, 8'h43, 2'd3, 1, 0, 5'd1, 8'h00);
      // Write A5h to address 5, read it back.
      add(3'b010, 3'b000, 3'b010, A5, W5, 3'b010, 3'b001, 8'h41, 2'd3, 1, 1, 5'd5, 8'hA5);
      add(3'b010, 3'b000, 3'b000, A5, W, 3'b010, 3'b000, 8'h00, 2'd3, 1, 0, 5'd5, 8'h00);
      add(3'b000, 3'b000, 3'b000, A, W, 3'b000, 3'b010, 8'hA5, 2'd3, 0, 0, 5'd0, 8'h00);
      for (int i = 0; i < 3; i++)
         add(3'b000, 3'b000, 3'b000, A, W, 3'b000, 3'b000, 8'h00, 2'd3, 0, 0, 5'd0, 8'h00);
      // Idle kept last=1, so requester 2 is next.
      add(3'b111, 3'b000, 3'b000, A, W, 3'b100, 3'b000, 8'h00, 2'd3, 1, 0, 5'd3, 8'h00);
      add(3'b010, 3'b000, 3'b000, A, W, 3'b010, 3'b100, 8'h43, 2'd3, 1, 0, 5'd2, 8'h00);
      // Loader locks for 8 cycles, fetch gets one slot, loader relocks.
      add(3'b101, 3'b100, 3'b000, A, W, 3'b100, 3'b010, 8'h42, 2'd3, 1, 0, 5'd3, 8'h00);
      for (int i = 0; i < 7; i++)
         add(3'b101, 3'b100, 3'b000, A, W, 3'b100, 3'b100, 8'h43, 2'd2, 1, 0, 5'd3, 8'h00);
      add(3'b101, 3'b100, 3'b000, A, W, 3'b001, 3'b100, 8'h43, 2'd3, 1, 0, 5'd1, 8'h00);
      add(3'b101, 3'b100, 3'b000, A, W, 3'b100, 3'b001, 8'h41, 2'd3, 1, 0, 5'd3, 8'h00);
      add(3'b101, 3'b100, 3'b000, A, W, 3'b100, 3'b100, 8'h43, 2'd2, 1, 0, 5'd3, 8'h00);
      // Lock drops in third locked cycle: normal arbitration that cycle.
      add(3'b011, 3'b000, 3'b000, A, W, 3'b001, 3'b100, 8'h43, 2'd2, 1, 0, 5'd1, 8'h00);
      add(3'b000, 3'b000, 3'b000, A, W, 3'b000, 3'b001, 8'h41, 2'd3, 0, 0, 5'd0, 8'h00);
      // Lock from a non-winner has no effect.
      add(3'b001, 3'b010, 3'b000, A, W, 3'b001, 3'b000, 8'h00, 2'd3, 1, 0, 5'd1, 8'h00);
      add(3'b000, 3'b000, 3'b000, A, W, 3'b000, 3'b001, 8'h41, 2'd3, 0, 0, 5'd0, 8'h00);
      // Locked owner idle blocks others; release lets fetch in.
      add(3'b100, 3'b100, 3'b000, A, W, 3'b100, 3'b000, 8'h00, 2'd3, 1, 0, 5'd3, 8'h00);
      add(3'b001, 3'b100, 3'b000, A, W, 3'b000, 3'b100, 8'h43, 2'd2, 0, 0, 5'd0, 8'h00);
      add(3'b001, 3'b000, 3'b000, A, W, 3'b001, 3'b000, 8'h00, 2'd2, 1, 0, 5'd1, 8'h00);
      add(3'b000, 3'b000, 3'b000, A, W, 3'b000, 3'b001, 8'h41, 2'd3, 0, 0, 5'd0, 8'h00);

      // Reset behaviour.
      rst = 1'b1;
      drive(3'b111, 3'b000, 3'b000, A, W);
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      @(negedge clk);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_owner", 32'(owner), 32'h3);
      chk("rst_rdata", 32'(rdata), 32'h0);

      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         rst = 1'b0;
         drive(tbl[i].req, tbl[i].lock, tbl[i].we, tbl[i].addr, tbl[i].wdata);
         @(negedge clk);
         chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rvalid));
         chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(tbl[i].rdata));
         chk($sformatf("v%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
         chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].en));
         if (tbl[i].en) begin
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].mwe));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
            if (tbl[i].mwe)
               chk($sformatf("v%0d_mem_din", i), 32'(mem_din), 32'(tbl[i].mdin));
         end
      end

      // Reset raised on a read grant cycle (last=0 before reset).
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(3'b010, 3'b000, 3'b000, A, W);
      @(negedge clk);
      chk("rstgnt_gnt", 32'(gnt), 32'h0);
      chk("rstgnt_mem_en", 32'(mem_en), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(3'b111, 3'b000, 3'b000, A, W);
      @(negedge clk);
      chk("post_rst_rvalid", 32'(rvalid), 32'h0);
      chk("post_rst_gnt", 32'(gnt), 32'h1);

      // Loader alone: forced release, lock ignored for one cycle, then relock.
      for (int k = 0; k < 11; k++) begin
         @(posedge clk);
         #1;
         drive(3'b100, 3'b100, 3'b000, A, W);
         @(negedge clk);
         chk($sformatf("fr%0d_gnt", k), 32'(gnt), 32'h4);
         chk($sformatf("fr%0d_owner", k), 32'(owner),
             (k == 0 || k == 8 || k == 9) ? 32'h3 : 32'h2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- AW, 5, address width.
- DW, 8, data width.
- MAX_LOCK, 8, maximum consecutive lock cycles; legal range 2..255.
REQ-002 Ports (name direction width meaning) SHALL be:
- clk in 1: clock; single clock domain.
- rst in 1: synchronous, active-high reset.
- req in 3: access request; bit0 instruction fetch, bit1 data, bit2 loader.
- lock in 3: per-requester hold of memory ownership.
- req_we in 3: 1 = write, 0 = read.
- req_addr in 3*AW: address, slice i = requester i.
- req_wdata in 3*DW: write data, slice i.
- gnt out 3: one-hot or zero grant, combinational.
- rvalid out 3: one-hot or zero read-data valid, registered.
- rdata out DW: read data, valid when any rvalid bit is set.
- mem_en out 1, mem_we out 1, mem_addr out AW, mem_din out DW: single-port memory drive, combinational.
- mem_dout in DW: memory read data, 1-cycle synchronous latency.
- owner out 2: current lock owner index; 3 = none.

Function
REQ-003 State SHALL be ARB or LOCKED, with registers last (2b), owner (2b) and lcnt (8b).
REQ-004 ARB: winner SHALL be the first i with req[i]=1 scanning (last+1) mod 3, (last+2) mod 3, last.
REQ-005 Grant cycle T: gnt[winner]=1; mem_en=1; mem_we/mem_addr/mem_din SHALL equal winner's req_we/addr/wdata slice; last<=winner.
REQ-006 No request in ARB: gnt=0, mem_en=0, last unchanged.
REQ-007 Grant in ARB with lock[winner]=1: next state LOCKED, owner<=winner, lcnt<=1.
REQ-008 LOCKED with lock[owner]=1: only owner eligible; gnt[owner]=req[owner]; mem driven only when granted; lcnt increments every cycle.
REQ-009 LOCKED with lock[owner]=0: that cycle SHALL arbitrate exactly as ARB (REQ-004..007); owner<=3 unless relocked.
REQ-010 Forced release: when lcnt reaches MAX_LOCK, next state SHALL be ARB with owner=3, and lock of the former owner SHALL be ignored for one ARB cycle.
REQ-011 Read granted in cycle T: rvalid[i]=1 and rdata=mem_dout in T+1 only; writes produce no rvalid.
REQ-012 Back-to-back grants SHALL be supported, one access per cycle, with no bubble.
REQ-013 At most one gnt bit and at most one rvalid bit SHALL be set per cycle.
REQ-014 lock[i] with req[i]=0 in ARB SHALL have no effect.

Reset
REQ-015 While rst=1: gnt=0, mem_en=0, mem_we=0, rvalid=0.
REQ-016 Reset SHALL load state=ARB, last=2 (first priority to requester 0), owner=3, lcnt=0, rdata=0.
REQ-017 A read granted in the cycle rst rises SHALL produce no rvalid.

Verification
REQ-018 Directed scenarios:
- Reset; req=111 (all reads) held -> gnt 001,010,100,001,... each cycle; rvalid trails gnt by 1 cycle with matching mem_dout.
- req=010, we=1, addr=5, wdata=A5h; next cycle read addr 5 -> rvalid=010 two cycles after the write grant, rdata=A5h.
- MAX_LOCK=8; loader req+lock held, fetch req held -> gnt=100 for 8 cycles, then 001 once, then loader relocks.
- Loader locked; lock[2] drops in cycle 3 with req=011 -> that cycle gnt=001, state ARB, owner=3.
- Read granted; rst asserted in the grant cycle -> rvalid=0 next cycle; first post-reset grant goes to requester 0.
- req=000 for 4 cycles -> mem_en=0, gnt=0, last unchanged.
